fifo_rd_32_to_128: RTL and testbench

FIFO_RD_32_TO_128 -- requirements
Module: fifo_rd_32_to_128

---
 rtl/fifo_rd_32_to_128_pkg.sv | 27 ++
 rtl/fifo_rd_32_to_128.sv | 139 +++++++++++++
 tb/tb_fifo_rd_32_to_128.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_32_to_128_pkg.sv
// Purpose : shared definitions for the OPB fifo width converters
//           (fifo_rd_32_to_128 and fifo_wr_128_to_32).
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: converter FSM state encoding, default narrow/wide widths and
//           the number of narrow lanes per wide word.
package fifo_rd_32_to_128_pkg;

  // Narrow (OPB fifo) word width and wide (assembled) word width defaults.
  localparam int I_W_WIDTH_DEF = 32;
  localparam int O_W_WIDTH_DEF = 128;

  // Narrow words per wide word.
  localparam int LANES = 4;

  // Converter state encoding. Encodings 6 and 7 are unused and recover
  // to ST_INIT.
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_POP0 = 3'd1,
    ST_POP1 = 3'd2,
    ST_POP2 = 3'd3,
    ST_POP3 = 3'd4,
    ST_FULL = 3'd5
  } fifo_state_e;

endpackage : fifo_rd_32_to_128_pkg

// File: rtl/fifo_rd_32_to_128.sv
// Purpose : reads four narrow words from a first-word-fall-through OPB fifo
//           and presents them as one wide word (first word in the top lane).
// Latency : one capture every 2 cycles; rdy rises the cycle after the 4th
//           capture (captures at 0,2,4,6 -> rdy at 7 with data always there).
// Backpressure: stalls in the current lane while not_empty=0; stops popping
//           while rdy=1 until the consumer pulses i_pull.
//
// Ports:
//   clk       single clock, all state changes on posedge
//   reset     asynchronous, active-high
//   idata     head word of the OPB fifo, valid while not_empty
//   not_empty OPB fifo holds at least one word
//   o_pop     registered one-cycle pop strobe to the OPB fifo
//   odata     registered assembled word
//   rdy       registered, odata holds a complete word
//   i_pull    consumer takes odata, honoured only while rdy=1
//
// Build option: define FIFO_RD_BYTE_SWAP_EN to byte-reverse every captured
// narrow word before it is stored in its lane. Timing is identical either way.
module fifo_rd_32_to_128
  import fifo_rd_32_to_128_pkg::*;
#(
  parameter int i_w_width = I_W_WIDTH_DEF,
  parameter int o_w_width = O_W_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [i_w_width-1:0] idata,
  input  logic                 not_empty,
  output logic                 o_pop,
  output logic [o_w_width-1:0] odata,
  output logic                 rdy,
  input  logic                 i_pull
);

  fifo_state_e          state;
  logic [o_w_width-1:0] shadow;
  logic [o_w_width-1:0] shadow_nxt;
  logic [i_w_width-1:0] cap_word;
  logic [1:0]           lane;
  logic                 cap_en;

  // Capture-path data formatting.
`ifdef FIFO_RD_BYTE_SWAP_EN
  // Byte b of the stored word comes from byte (nbytes-1-b) of the fifo word.
  localparam int NBYTES = i_w_width / 8;
  for (genvar b = 0; b < NBYTES; b++) begin : g_swap
    assign cap_word[b*8 +: 8] = idata[(NBYTES-1-b)*8 +: 8];
  end
`else
  assign cap_word = idata;
`endif

  // Capture is allowed only in a popN state when the fifo has a word and
  // no pop is in flight. The o_pop term keeps us from re-reading the head
  // word before the fifo has advanced past it, so pops are never
  // back to back.
  always_comb begin
    cap_en = 1'b0;
    lane   = 2'd0;
    case (state)
      ST_POP0: begin cap_en = not_empty && !o_pop; lane = 2'd0; end
      ST_POP1: begin cap_en = not_empty && !o_pop; lane = 2'd1; end
      ST_POP2: begin cap_en = not_empty && !o_pop; lane = 2'd2; end
      ST_POP3: begin cap_en = not_empty && !o_pop; lane = 2'd3; end
      default: begin cap_en = 1'b0; lane = 2'd0; end
    endcase
  end

  // Lane 0 is the most significant narrow slice of the wide word.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[o_w_width-1-int'(lane)*i_w_width -: i_w_width] = cap_word;
  end

  // Single-process FSM; all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_INIT;
      o_pop  <= 1'b0;
      rdy    <= 1'b0;
      odata  <= '0;
      shadow <= '0;
    end else begin
      // Pop strobe is a single-cycle pulse following each capture.
      o_pop <= 1'b0;
      case (state)
        ST_INIT: begin
          state <= ST_POP0;
        end
        ST_POP0: begin
          if (cap_en) begin
            shadow <= shadow_nxt;
            o_pop  <= 1'b1;
            state  <= ST_POP1;
          end
        end
        ST_POP1: begin
          if (cap_en) begin
            shadow <= shadow_nxt;
            o_pop  <= 1'b1;
            state  <= ST_POP2;
          end
        end
        ST_POP2: begin
          if (cap_en) begin
            shadow <= shadow_nxt;
            o_pop  <= 1'b1;
            state  <= ST_POP3;
          end
        end
        ST_POP3: begin
          // Last lane: publish the full word straight from the merged
          // shadow so odata/rdy appear one cycle after the capture.
          if (cap_en) begin
            shadow <= shadow_nxt;
            odata  <= shadow_nxt;
            rdy    <= 1'b1;
            o_pop  <= 1'b1;
            state  <= ST_FULL;
          end
        end
        ST_FULL: begin
          // odata is left untouched so it stays stable until the next fill
          // completes.
          if (i_pull) begin
            rdy   <= 1'b0;
            state <= ST_POP0;
          end
        end
        default: begin
          rdy   <= 1'b0;
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule : fifo_rd_32_to_128

// File: tb/tb_fifo_rd_32_to_128.sv
// Purpose : directed self-checking bench for fifo_rd_32_to_128 with a
//           first-word-fall-through fifo model and an expected-word queue.
// Latency : checks capture/pop spacing and rdy timing of every fill.
// Backpressure: exercises not_empty gaps, long holds with i_pull low,
//           stray i_pull during fills and reset in the middle of a fill.
module tb_fifo_rd_32_to_128;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  idata;
  logic         not_empty;
  logic         o_pop;
  logic [127:0] odata;
  logic         rdy;
  logic         i_pull;

  always #5 clk = ~clk;

  fifo_rd_32_to_128 #(.i_w_width(32), .o_w_width(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .idata     (idata),
    .not_empty (not_empty),
    .o_pop     (o_pop),
    .odata     (odata),
    .rdy       (rdy),
    .i_pull    (i_pull)
  );

  // First-word-fall-through fifo model.
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        ne_en;
  int          cyc = 0;
  int          underflow = 0;

  assign not_empty = ne_en && (wr_ptr != rd_ptr);
  assign idata     = (wr_ptr != rd_ptr) ? mem[rd_ptr[5:0]] : 32'h0;

  always @(posedge clk) begin
    cyc++;
    if (o_pop) begin
      if (wr_ptr != rd_ptr) rd_ptr++;
      else underflow++;
    end
  end

  // Scoreboard and bookkeeping.
  logic [127:0] exp_q [$];
  int           pop_t [$];
  int           t_rdy;
  int           odata_changes;
  int           n_checks = 0;
  int           n_errors = 0;

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef FIFO_RD_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  task automatic push4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    push_word(a); push_word(b); push_word(c); push_word(d);
    exp_q.push_back({sw(a), sw(b), sw(c), sw(d)});
  endtask

  // Wait (bounded) for rdy, logging o_pop cycles and odata changes while
  // rdy=0. With noise set, i_pull is held high for the whole fill.
  task automatic wait_word(input int budget, input logic noise);
    logic [127:0] prev;
    bit           done;
    done = 0;
    pop_t.delete();
    odata_changes = 0;
    t_rdy = -1;
    prev = odata;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (o_pop) pop_t.push_back(cyc);
      if (rdy) begin
        t_rdy  = cyc;
        done   = 1;
        i_pull = 1'b0;
      end else begin
        if (odata !== prev) odata_changes++;
        prev   = odata;
        i_pull = noise;
      end
    end
    i_pull = 1'b0;
    checki("word_done", int'(done), 1);
  endtask

  // Captures 0,2,4,6 -> pops sampled 1,3,5,7 and rdy at 7.
  task automatic check_timing(input string tag);
    checki({tag, "_npop"}, pop_t.size(), 4);
    if (pop_t.size() == 4) begin
      checki({tag, "_pop1"}, pop_t[1] - pop_t[0], 2);
      checki({tag, "_pop2"}, pop_t[2] - pop_t[0], 4);
      checki({tag, "_pop3"}, pop_t[3] - pop_t[0], 6);
      checki({tag, "_rdy"},  t_rdy    - pop_t[0], 6);
    end
  endtask

  task automatic check_word(input string tag);
    logic [127:0] e;
    checki({tag, "_sb_has"}, int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, odata, e);
    end
  endtask

  // Pull the current word: rdy must drop and odata must not move.
  task automatic pull(input string tag);
    logic [127:0] held;
    held = odata;
    @(negedge clk);
    i_pull = 1'b1;
    @(negedge clk);
    i_pull = 1'b0;
    checki({tag, "_rdy_drop"}, int'(rdy), 0);
    check({tag, "_odata_kept"}, odata, held);
  endtask

  task automatic wait_pops(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 40 && seen < n; i++) begin
      @(negedge clk);
      if (o_pop) seen++;
    end
    checki("wait_pops", seen, n);
  endtask

  initial begin
    int           rel;
    int           bad;
    logic [127:0] held;

    reset  = 1'b1;
    ne_en  = 1'b0;
    i_pull = 1'b0;
    repeat (3) @(negedge clk);
    checki("reset_o_pop", int'(o_pop), 0);
    checki("reset_rdy",   int'(rdy),   0);
    check ("reset_odata", odata, 128'h0);

    // Steady not_empty, basic fill and reset-release latency.
    push4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    ne_en = 1'b1;
    reset = 1'b0;
    rel   = cyc;
    wait_word(40, 1'b0);
    if (pop_t.size() > 0) checki("rst_to_first_pop_ge2", int'((pop_t[0] - rel) >= 2), 1);
    check_timing("steady");
    check_word("steady_word");

    // Hold full for 20 cycles with words available.
    push4(32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0BADF00D);
    held = odata;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_pop || !rdy || odata !== held) bad++;
    end
    checki("hold_full", bad, 0);
    pull("hold");
    wait_word(40, 1'b0);
    checki("fill_odata_stable", odata_changes, 0);
    check_timing("after_hold");
    check_word("after_hold_word");

    // Stray i_pull during a fill is ignored.
    push4(32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F);
    pull("noise");
    wait_word(40, 1'b1);
    checki("noise_odata_stable", odata_changes, 0);
    check_timing("noise");
    check_word("noise_word");

    // not_empty gap of 5 cycles after the second capture.
    push4(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    pull("gap");
    wait_pops(2);
    ne_en = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_pop) bad++;
    end
    checki("gap_no_pop", bad, 0);
    ne_en = 1'b1;
    wait_word(40, 1'b0);
    checki("gap_remaining_pops", pop_t.size(), 2);
    check_word("gap_word");

    // Reset after the second capture discards the partial word.
    push_word(32'hBAD00001);
    push_word(32'hBAD00002);
    push4(32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0);
    pull("rst");
    wait_pops(2);
    ne_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checki("midfill_rst_o_pop", int'(o_pop), 0);
    checki("midfill_rst_rdy",   int'(rdy),   0);
    check ("midfill_rst_odata", odata, 128'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ne_en = 1'b1;
    wait_word(40, 1'b0);
    check_timing("after_rst");
    check_word("after_rst_word");

    // Every fifo word consumed exactly once, never popped while empty.
    repeat (3) @(negedge clk);
    checki("fifo_underflow", underflow, 0);
    checki("fifo_drained", rd_ptr, wr_ptr);
    checki("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_fifo_rd_32_to_128
